apu_seq: RTL
============

# apu_seq

Instruction sequencer for the APU datapath, directly downstream of the AHB slave/address-map stage. It starts when `apu_ready` rises and fetches 32-bit instruction words from the IR RAM read port, written earlier over AHB. Each word is issued to the compute engine over a valid/ready handshake, and the sequencer waits for `op_done` before fetching the next word. At END, error or abort it returns to idle; END and error completion raise a one-cycle `cal_cpl`, which feeds the address map's `cal_cpl`/`int_cal` logic.

## Interface
Clock `hclk`; reset `hresetn`, synchronous, active-low.

Parameters:
- IR_AW, 4, IR RAM address width; the program depth is 2^IR_AW words.
- TIMEOUT, 65535, maximum number of cycles to wait for `op_done` after a handshake.

Ports:
- hclk  in  1  clock
- hresetn  in  1  synchronous active-low reset
- apu_ready  in  1  run enable from the address map; a rising edge starts a run, a falling edge aborts it
- ir_rd_en  out  1  IR RAM read enable
- ir_rd_addr  out  IR_AW  IR RAM read address (the program counter)
- ir_rd_data  in  32  IR RAM data, valid one cycle after `ir_rd_en`
- instr_valid  out  1  instruction offered to the engine
- instr_ready  in  1  engine accepts the instruction
- instr_opcode  out  4  `ir_rd_data[31:28]`, registered
- instr_operand  out  28  `ir_rd_data[27:0]`, registered
- op_done  in  1  single-cycle pulse: the engine finished the current instruction
- cal_cpl  out  1  single-cycle pulse: run finished (END or error)
- seq_busy  out  1  high in every state except IDLE
- seq_err  out  1  sticky error flag; cleared at the next start
- err_code  out  2  0 none, 1 illegal opcode, 2 no END before the PC wraps, 3 timeout

## Operation
- Opcodes: 0 NOP, 1 CONV, 2 BN, 3 POOL, 4 ACT, F END; 5..E are illegal.
- States: IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_DONE, DONE, ERR.
- IDLE → FETCH when `apu_ready` is 1 and its registered copy is 0. On this transition: pc←0, seq_err←0, err_code←0.
- FETCH:
  - `ir_rd_en`=1, `ir_rd_addr`=pc.
  - Next state is WAIT_DATA.
- WAIT_DATA: decode `ir_rd_data`.
  - NOP: pc+1, go to FETCH.
  - END: go to DONE.
  - Illegal opcode: err_code=1, go to ERR.
  - Otherwise: latch opcode and operand, go to ISSUE.
- ISSUE:
  - `instr_valid`=1; opcode and operand are held stable until the handshake.
  - On `instr_valid`&`instr_ready`, go to WAIT_DONE and clear the watchdog.
- WAIT_DONE:
  - On `op_done`: pc+1, go to FETCH.
  - If the watchdog reaches TIMEOUT: err_code=3, go to ERR.
- PC wrap: if pc = 2^IR_AW−1 and pc must advance (after NOP or `op_done`), set err_code=2 and go to ERR instead of wrapping.
- DONE: `cal_cpl`=1 for one cycle, then IDLE.
- ERR: `cal_cpl`=1 and seq_err←1 for one cycle, then IDLE. err_code holds until the next start.
- Abort: `apu_ready`=0 in any non-IDLE state sends the FSM to IDLE on the next cycle. Abort produces no `cal_cpl`, drops `instr_valid` and leaves seq_err unchanged. Abort takes priority over every other transition.
- Ignored events:
  - `op_done` outside WAIT_DONE.
  - A rising edge of `apu_ready` while busy.
- Simultaneous `op_done` and timeout at the same edge: `op_done` wins.

## Timing
- Reset values: all outputs 0; state IDLE; pc 0; watchdog 0; registered `apu_ready` 0.
- Start: with the `apu_ready` edge sampled at cycle t, the FSM is in FETCH at t+1, WAIT_DATA at t+2 and ISSUE at t+3, so the first `instr_valid` is at t+3.
- Per-instruction overhead:
  - 3 cycles from `op_done` to the next `instr_valid`.
  - 2 cycles per NOP.
- END: END fetched at cycle f → `cal_cpl` high at f+2, IDLE at f+3.
- All outputs are registered; there is no combinational path from any input to any output.
- The watchdog is 16 bits wide, saturating. It counts only in WAIT_DONE.

## Structure
- Package `apu_seq_pkg`:
  - opcode constants
  - the state enumeration
  - err_code constants
  - the instruction field slice positions
- Sub-module `apu_watchdog`: a saturating counter with clear and enable inputs and a `expired` output; TIMEOUT is passed down as a parameter.

## Test plan
- Program CONV, BN, END with the engine ready immediately and `op_done` 4 cycles after each handshake → two handshakes with opcodes 1 then 2, `cal_cpl` exactly once, seq_err=0.
- Program NOP, NOP, POOL, END → NOPs are never issued; first `instr_valid` at t+7; pc=3 when `cal_cpl` fires.
- Word 0 = 0x7000_0000 → no handshake; `cal_cpl` at t+3; seq_err=1, err_code=1.
- All 16 words = ACT with `op_done` returned each time → 16 issues, then err_code=2 and `cal_cpl`.
- TIMEOUT=20, `op_done` withheld → ERR 20 cycles after the handshake with err_code=3. A second case delivers `op_done` and timeout at the same edge → normal advance.
- `apu_ready` dropped while in ISSUE with `instr_ready`=0 → IDLE next cycle, `instr_valid`=0, no `cal_cpl`. A re-raise then restarts the run from pc=0.

Source files
------------

// File: rtl/apu_seq_pkg.sv
// rtl/apu_seq_pkg.sv - shared opcodes, states, error codes and field positions for the APU sequencer
package apu_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_CONV = 4'h1;
    localparam logic [3:0] OP_BN   = 4'h2;
    localparam logic [3:0] OP_POOL = 4'h3;
    localparam logic [3:0] OP_ACT  = 4'h4;
    localparam logic [3:0] OP_END  = 4'hF;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_WRAP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int OPR_MSB = 27;
    localparam int OPR_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_ISSUE,
        S_WAIT_DONE,
        S_DONE,
        S_ERR
    } seq_state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_ACT) || (op == OP_END);
    endfunction

endpackage

// File: rtl/apu_seq_if.sv
// rtl/apu_seq_if.sv - sequencer bundle: run control, IR RAM read port, engine handshake, status
interface apu_seq_if #(
    parameter int IR_AW = 4
);
    logic             apu_ready;
    logic             ir_rd_en;
    logic [IR_AW-1:0] ir_rd_addr;
    logic [31:0]      ir_rd_data;
    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       instr_opcode;
    logic [27:0]      instr_operand;
    logic             op_done;
    logic             cal_cpl;
    logic             seq_busy;
    logic             seq_err;
    logic [1:0]       err_code;

    modport master (
        input  apu_ready, ir_rd_data, instr_ready, op_done,
        output ir_rd_en, ir_rd_addr, instr_valid, instr_opcode, instr_operand,
               cal_cpl, seq_busy, seq_err, err_code
    );

    modport slave (
        output apu_ready, ir_rd_data, instr_ready, op_done,
        input  ir_rd_en, ir_rd_addr, instr_valid, instr_opcode, instr_operand,
               cal_cpl, seq_busy, seq_err, err_code
    );
endinterface

// File: rtl/apu_watchdog.sv
// rtl/apu_watchdog.sv - 16-bit saturating wait counter with clear/enable and expiry flag
module apu_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    logic [15:0] r_count;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Count holds the number of completed waiting cycles, so expiry flags the TIMEOUT-th cycle itself.
    assign o_expired = (r_count >= 16'(TIMEOUT - 1));
endmodule

// File: rtl/apu_seq.sv
// rtl/apu_seq.sv - APU instruction sequencer: fetch from IR RAM, issue to engine, wait for completion
module apu_seq
    import apu_seq_pkg::*;
#(
    parameter int IR_AW   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic      hclk,
    input  logic      hresetn,
    apu_seq_if.master bus
);
    seq_state_t       r_state;
    seq_state_t       w_next;
    logic             r_ready_q;
    logic [IR_AW-1:0] r_pc;
    logic [IR_AW-1:0] w_pc_next;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_next;
    logic             r_seq_err;
    logic [3:0]       r_opcode;
    logic [27:0]      r_operand;
    logic             r_rd_en;
    logic             r_valid;
    logic             r_cal;
    logic             r_busy;
    logic             w_latch;
    logic             w_clear_wd;
    logic             w_expired;
    logic             w_start;
    logic             w_pc_last;
    logic [3:0]       w_rd_op;

    assign w_start   = bus.apu_ready & ~r_ready_q;
    assign w_pc_last = &r_pc;
    assign w_rd_op   = bus.ir_rd_data[OPC_MSB:OPC_LSB];

    apu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .i_clear   (w_clear_wd),
        .i_en      (r_state == S_WAIT_DONE),
        .o_expired (w_expired)
    );

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_err_next = r_err_code;
        w_latch    = 1'b0;
        w_clear_wd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next     = S_FETCH;
                    w_pc_next  = '0;
                    w_err_next = ERR_NONE;
                end
            end
            S_FETCH: w_next = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (w_rd_op == OP_NOP) begin
                    if (w_pc_last) begin
                        w_next     = S_ERR;
                        w_err_next = ERR_WRAP;
                    end else begin
                        w_next    = S_FETCH;
                        w_pc_next = r_pc + 1'b1;
                    end
                end else if (w_rd_op == OP_END) begin
                    w_next = S_DONE;
                end else if (!is_legal(w_rd_op)) begin
                    w_next     = S_ERR;
                    w_err_next = ERR_ILLEGAL;
                end else begin
                    w_next  = S_ISSUE;
                    w_latch = 1'b1;
                end
            end
            S_ISSUE: begin
                if (r_valid && bus.instr_ready) begin
                    w_next     = S_WAIT_DONE;
                    w_clear_wd = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                // op_done is checked first so a completion on the expiry cycle still advances.
                if (bus.op_done) begin
                    if (w_pc_last) begin
                        w_next     = S_ERR;
                        w_err_next = ERR_WRAP;
                    end else begin
                        w_next    = S_FETCH;
                        w_pc_next = r_pc + 1'b1;
                    end
                end else if (w_expired) begin
                    w_next     = S_ERR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && !bus.apu_ready) begin
            w_next     = S_IDLE;
            w_pc_next  = r_pc;
            w_err_next = r_err_code;
            w_latch    = 1'b0;
            w_clear_wd = 1'b0;
        end
    end

    // Outputs are decoded from the next state so every port is a flop with no input-to-output path.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_ready_q  <= 1'b0;
            r_pc       <= '0;
            r_err_code <= ERR_NONE;
            r_seq_err  <= 1'b0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_rd_en    <= 1'b0;
            r_valid    <= 1'b0;
            r_cal      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready_q  <= bus.apu_ready;
            r_pc       <= w_pc_next;
            r_err_code <= w_err_next;
            if ((r_state == S_IDLE) && (w_next == S_FETCH)) begin
                r_seq_err <= 1'b0;
            end else if (w_next == S_ERR) begin
                r_seq_err <= 1'b1;
            end
            if (w_latch) begin
                r_opcode  <= bus.ir_rd_data[OPC_MSB:OPC_LSB];
                r_operand <= bus.ir_rd_data[OPR_MSB:OPR_LSB];
            end
            r_rd_en <= (w_next == S_FETCH);
            r_valid <= (w_next == S_ISSUE);
            r_cal   <= (w_next == S_DONE) || (w_next == S_ERR);
            r_busy  <= (w_next != S_IDLE);
        end
    end

    assign bus.ir_rd_en      = r_rd_en;
    assign bus.ir_rd_addr    = r_pc;
    assign bus.instr_valid   = r_valid;
    assign bus.instr_opcode  = r_opcode;
    assign bus.instr_operand = r_operand;
    assign bus.cal_cpl       = r_cal;
    assign bus.seq_busy      = r_busy;
    assign bus.seq_err       = r_seq_err;
    assign bus.err_code      = r_err_code;
endmodule
